xb_io_mbox_slv: RTL
===================

// Module: xb_io_mbox_slv
// PURPOSE
//  IO-bus responder (slave) on the core's io_arb_mux bus: the target end of the core's IO reads/writes.
//  Exposes CTRL/STAT/DATA registers backed by a TX FIFO (core->fabric stream) and an RX FIFO
//  (fabric->core stream); returns read data on stgi_xf_io_slv_* and raises xlr8_irq toward the core.
// PARAMETERS
//  DEPTH      8     entries per FIFO; power of 2, 2..8
//  ADDR_CTRL  6'h20 IO address of CTRL
//  ADDR_STAT  6'h21 IO address of STAT
//  ADDR_DATA  6'h22 IO address of DATA (write = TX push, read = RX pop)
// PORTS
//  clk                     in   1  core clock
//  rst                     in   1  asynchronous reset, active-high
//  io_arb_mux_adr          in   6  IO address from core
//  io_arb_mux_iore         in   1  IO read strobe
//  io_arb_mux_iowe         in   1  IO write strobe
//  io_arb_mux_dbusout      in   8  IO write data
//  stgi_xf_io_slv_dbusout  out  8  IO read data
//  stgi_xf_io_slv_out_en   out  1  read-data valid (this slave drives the bus)
//  xlr8_irq                out  1  interrupt request to core
//  xlr8_irq_ack            in   1  interrupt acknowledge from core (1-cycle pulse)
//  tx_valid/tx_data/tx_ready  out 1 / out 8 / in 1   TX stream to fabric
//  rx_valid/rx_data/rx_ready  in 1 / in 8 / out 1    RX stream from fabric
// BEHAVIOUR
//  - Reset: both FIFOs empty, CTRL=0, ovf flags=0, irq pending=0; all outputs 0.
//  - Reads are combinational: out_en = iore & adr in {CTRL,STAT,DATA}; dbusout = selected reg, else 0x00.
//  - Writes/pops take effect on the clk edge where iowe/iore is high with a matching address.
//  - CTRL: [0] EN, [1] RXIE, [2] TXIE, [7] FLUSH (write-1 self-clearing, reads 0); [6:3] read 0.
//  - STAT (read-only except W1C): [0] rx_nempty, [1] tx_full, [2] rx_ovf (W1C), [3] tx_empty,
//    [4] tx_ovf (W1C), [7:5] 0. Write with bit2/bit4 = 1 clears that flag.
//  - DATA write: if !tx_full push; if tx_full drop byte, set tx_ovf.
//  - DATA read: returns RX head (0x00 if empty); pop on that edge only if nonempty.
//  - TX stream: tx_valid = EN & !tx_empty; tx_data = TX head; pop when tx_valid & tx_ready.
//  - RX stream: rx_ready = EN & !rx_full; push when rx_valid & rx_ready; rx_valid & EN & rx_full sets rx_ovf.
//  - Simultaneous push+pop on same FIFO: both occur, count unchanged; legal at full (TX) and empty edges
//    per rules above (TX: full-write drop is evaluated before the same-cycle pop, i.e. still dropped).
//  - Pointers log2(DEPTH) bits, wrap modulo DEPTH; count log2(DEPTH)+1 bits, never exceeds DEPTH.
//  - EN=0: FIFO contents held, streams stalled; core DATA writes/reads still operate.
//  - FLUSH: empties both FIFOs on that edge (overrides same-cycle push/pop); ovf flags and CTRL[2:0]
//    take the written value normally.
//  - Async rst mid-transfer: immediate return to reset state; any partial stream beat is lost.
// CONFIGURATION
//  XB_IO_MBOX_IRQ_EN defined: irq pending set on edge where (RXIE & RX push) or (TXIE & TX goes
//   nonempty->empty); cleared by xlr8_irq_ack; a same-cycle set wins over ack. xlr8_irq = pending.
//  Not defined: xlr8_irq tied 0, xlr8_irq_ack ignored, CTRL[2:1] not stored and read 0.
// TESTING
//  1. Reset, read CTRL/STAT -> 0x00/0x08, out_en=1 only while iore & matching adr; other adr -> out_en=0.
//  2. EN=1, tx_ready=0, write 0x11..0x18 -> STAT=0x02; 9th write 0x99 dropped, STAT bit4=1;
//     tx_ready=1 -> tx_data 0x11..0x18 in order, then STAT bit3=1.
//  3. rx_valid with 0xA5,0x5A -> DATA reads 0xA5,0x5A, third read 0x00, STAT bit0=0.
//  4. Fill RX to 8, push 9th -> rx_ready=0, rx_ovf=1; write STAT 0x04 -> rx_ovf=0.
//  5. IRQ_EN build: RXIE=1, push 0x3C -> xlr8_irq=1 next cycle; ack -> 0; ack coincident with push -> stays 1.
//  6. FLUSH with 5 TX/3 RX entries and concurrent rx push -> both empty next cycle; assert rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/xb_io_mbox_slv_if.sv
// Purpose: core-side IO bus (io_arb_mux request / stgi_xf_io_slv response) seen by the mailbox slave.
// Latency: none; this is a bundle of wires.
// Backpressure: none on the IO bus; the core strobes and the slave answers combinationally.
// Ports: adr/iore/iowe/dbusout driven by the core (master); slave returns dbusout/out_en.
interface xb_io_mbox_slv_if;
    logic [5:0] io_arb_mux_adr;
    logic       io_arb_mux_iore;
    logic       io_arb_mux_iowe;
    logic [7:0] io_arb_mux_dbusout;
    logic [7:0] stgi_xf_io_slv_dbusout;
    logic       stgi_xf_io_slv_out_en;

    modport master (
        output io_arb_mux_adr, io_arb_mux_iore, io_arb_mux_iowe, io_arb_mux_dbusout,
        input  stgi_xf_io_slv_dbusout, stgi_xf_io_slv_out_en
    );

    modport slave (
        input  io_arb_mux_adr, io_arb_mux_iore, io_arb_mux_iowe, io_arb_mux_dbusout,
        output stgi_xf_io_slv_dbusout, stgi_xf_io_slv_out_en
    );
endinterface

// File: rtl/xb_io_mbox_slv.sv
// Purpose: IO-bus mailbox slave with CTRL/STAT/DATA registers over a TX FIFO (core->fabric) and RX FIFO (fabric->core).
// Latency: register reads combinational; writes, pops and stream beats take effect on the next clk edge.
// Backpressure: tx_valid/tx_ready and rx_valid/rx_ready; full TX drops core writes (tx_ovf), full RX stalls fabric (rx_ovf).
// Ports: clk, rst (async, active-high); io (xb_io_mbox_slv_if.slave); xlr8_irq/xlr8_irq_ack;
//        tx_valid/tx_data/tx_ready; rx_valid/rx_data/rx_ready.
// Build option: define XB_IO_MBOX_IRQ_EN to enable RXIE/TXIE and the interrupt request.
module xb_io_mbox_slv #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [5:0]  ADDR_CTRL = 6'h20,
    parameter logic [5:0]  ADDR_STAT = 6'h21,
    parameter logic [5:0]  ADDR_DATA = 6'h22
) (
    input  logic                   clk,
    input  logic                   rst,
    xb_io_mbox_slv_if.slave        io,
    output logic                   xlr8_irq,
    input  logic                   xlr8_irq_ack,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   rx_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    tx_mem_d [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    rx_mem_d [DEPTH];
    logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          en_q, en_d, tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;

    logic sel_ctrl, sel_stat, sel_data;
    logic ctrl_wr, stat_wr, data_wr, data_rd, flush;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0] tx_head, rx_head, ctrl_rd, stat_rd, rd_dat;

    assign sel_ctrl = (io.io_arb_mux_adr == ADDR_CTRL);
    assign sel_stat = (io.io_arb_mux_adr == ADDR_STAT);
    assign sel_data = (io.io_arb_mux_adr == ADDR_DATA);
    assign ctrl_wr  = io.io_arb_mux_iowe & sel_ctrl;
    assign stat_wr  = io.io_arb_mux_iowe & sel_stat;
    assign data_wr  = io.io_arb_mux_iowe & sel_data;
    assign data_rd  = io.io_arb_mux_iore & sel_data;
    assign flush    = ctrl_wr & io.io_arb_mux_dbusout[7];

    assign tx_full  = (tx_cnt_q == CW'(DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign tx_head  = tx_empty ? 8'h00 : tx_mem_q[tx_rd_q];
    assign rx_head  = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q];

    assign tx_valid = en_q & ~tx_empty;
    assign tx_data  = tx_head;
    assign rx_ready = en_q & ~rx_full;

    // Full check uses the pre-edge count, so a write at full is dropped even if the stream pops this cycle.
    assign tx_push  = data_wr & ~tx_full;
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = data_rd & ~rx_empty;

    assign stat_rd  = {3'b000, tx_ovf_q, tx_empty, rx_ovf_q, tx_full, ~rx_empty};

    always_comb begin
        rd_dat = 8'h00;
        if (sel_ctrl)      rd_dat = ctrl_rd;
        else if (sel_stat) rd_dat = stat_rd;
        else if (sel_data) rd_dat = rx_head;
    end

    assign io.stgi_xf_io_slv_out_en  = io.io_arb_mux_iore & (sel_ctrl | sel_stat | sel_data);
    assign io.stgi_xf_io_slv_dbusout = io.io_arb_mux_iore ? rd_dat : 8'h00;

    // FIFO and register next state; FLUSH overrides any same-edge push/pop.
    always_comb begin
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
        rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
        if (tx_push) begin
            tx_mem_d[tx_wr_q] = io.io_arb_mux_dbusout;
            tx_wr_d           = tx_wr_q + 1'b1;
        end
        if (tx_pop) tx_rd_d = tx_rd_q + 1'b1;
        if (rx_push) begin
            rx_mem_d[rx_wr_q] = rx_data;
            rx_wr_d           = rx_wr_q + 1'b1;
        end
        if (rx_pop) rx_rd_d = rx_rd_q + 1'b1;
        if (flush) begin
            tx_wr_d  = '0;
            tx_rd_d  = '0;
            tx_cnt_d = '0;
            rx_wr_d  = '0;
            rx_rd_d  = '0;
            rx_cnt_d = '0;
        end

        en_d = ctrl_wr ? io.io_arb_mux_dbusout[0] : en_q;
        // W1C is applied first so a same-edge overflow event still leaves the flag set.
        tx_ovf_d = tx_ovf_q & ~(stat_wr & io.io_arb_mux_dbusout[4]);
        rx_ovf_d = rx_ovf_q & ~(stat_wr & io.io_arb_mux_dbusout[2]);
        if (data_wr & tx_full)           tx_ovf_d = 1'b1;
        if (rx_valid & en_q & rx_full)   rx_ovf_d = 1'b1;
    end

`ifdef XB_IO_MBOX_IRQ_EN
    logic rxie_q, rxie_d, txie_q, txie_d, irq_q, irq_d, tx_drain;

    // A drain is the stream taking the last entry; a FLUSH is software-initiated and does not interrupt.
    assign tx_drain = tx_pop & ~tx_push & (tx_cnt_q == CW'(1)) & ~flush;

    always_comb begin
        rxie_d = ctrl_wr ? io.io_arb_mux_dbusout[1] : rxie_q;
        txie_d = ctrl_wr ? io.io_arb_mux_dbusout[2] : txie_q;
        irq_d  = irq_q & ~xlr8_irq_ack;
        if ((rxie_q & rx_push & ~flush) | (txie_q & tx_drain)) irq_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxie_q <= 1'b0;
            txie_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            rxie_q <= rxie_d;
            txie_q <= txie_d;
            irq_q  <= irq_d;
        end
    end

    assign ctrl_rd  = {5'b00000, txie_q, rxie_q, en_q};
    assign xlr8_irq = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = xlr8_irq_ack;
    assign ctrl_rd        = {7'b0000000, en_q};
    assign xlr8_irq       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tx_mem_q[i] <= 8'h00;
                rx_mem_q[i] <= 8'h00;
            end
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            en_q     <= 1'b0;
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            tx_mem_q <= tx_mem_d;
            rx_mem_q <= rx_mem_d;
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            en_q     <= en_d;
            tx_ovf_q <= tx_ovf_d;
            rx_ovf_q <= rx_ovf_d;
        end
    end
endmodule
